// File: rtl/ysyx_23060240_axi_pkg.sv
// Shared constants, FSM state types and address decode helper for the
// AXI4-Lite SRAM responder.
package ysyx_23060240_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off < bytes);
  endfunction

endpackage

// File: rtl/ysyx_23060240_axi_sram_if.sv
// AXI4-Lite bus bundle between a fetch/load-store master and the SRAM responder.
interface ysyx_23060240_axi_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060240_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to draw per-transaction latencies.
module ysyx_23060240_lfsr8
  import ysyx_23060240_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;
endmodule

// File: rtl/ysyx_23060240_axi_sram.sv
// AXI4-Lite SRAM responder: independent read/write FSMs over one word array,
// with fixed or LFSR-drawn response latency. All outputs are registered.
module ysyx_23060240_axi_sram
  import ysyx_23060240_axi_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH      = 4096,
  parameter int          RD_DELAY   = 0,
  parameter int          WR_DELAY   = 0,
  parameter bit          RAND_DELAY = 1'b0
) (
  input logic clk,
  input logic rst,
  ysyx_23060240_axi_sram_if.slave bus
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] BYTES = 32'(4 * DEPTH);

  logic [31:0] mem [DEPTH];

  logic [7:0] lfsr, rdly, wdly;
  ysyx_23060240_lfsr8 u_lfsr (.clk(clk), .rst(rst), .out(lfsr));

  assign rdly = RAND_DELAY ? (lfsr & 8'h07) : 8'(RD_DELAY);
  assign wdly = RAND_DELAY ? (lfsr & 8'h07) : 8'(WR_DELAY);

  // ---------------- read channel ----------------
  rd_state_e   rstate_q, rstate_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic        rsample, rhit;
  logic [AW-1:0] ridx;

  always_comb begin
    rstate_d  = rstate_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rsample   = 1'b0;
    unique case (rstate_q)
      R_IDLE: if (bus.arvalid && arready_q) begin
        raddr_d   = bus.araddr;
        arready_d = 1'b0;
        if (rdly == 8'd0) begin
          rsample  = 1'b1;
          rstate_d = R_RESP;
        end else begin
          rcnt_d   = rdly;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rcnt_d = rcnt_q - 8'd1;
        if (rcnt_q == 8'd1) begin
          rsample  = 1'b1;
          rstate_d = R_RESP;
        end
      end
      R_RESP: if (bus.rready) begin
        rvalid_d  = 1'b0;
        arready_d = 1'b1;
        rstate_d  = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
    rhit = addr_hit(raddr_d, BASE, BYTES);
    ridx = AW'((raddr_d - BASE) >> 2);
    // Array read sees pre-edge contents, so a same-edge write returns old data
    if (rsample) begin
      rvalid_d = 1'b1;
      rresp_d  = rhit ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rhit ? mem[ridx] : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q  <= R_IDLE;
      rcnt_q    <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // ---------------- write channel ----------------
  wr_state_e   wstate_q, wstate_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        wcommit, whit, mem_we;
  logic [AW-1:0] widx;

  always_comb begin
    wstate_d  = wstate_q;
    wcnt_d    = wcnt_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wcommit   = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        if (bus.awvalid && awready_q) begin
          awaddr_d  = bus.awaddr;
          aw_got_d  = 1'b1;
          awready_d = 1'b0;
        end
        if (bus.wvalid && wready_q) begin
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
          w_got_d  = 1'b1;
          wready_d = 1'b0;
        end
        // Latency is drawn once both halves are held, from the later handshake
        if (aw_got_d && w_got_d) begin
          if (wdly == 8'd0) begin
            wcommit  = 1'b1;
            wstate_d = W_RESP;
          end else begin
            wcnt_d   = wdly;
            wstate_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        wcnt_d = wcnt_q - 8'd1;
        if (wcnt_q == 8'd1) begin
          wcommit  = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (bus.bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        wstate_d  = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    whit   = addr_hit(awaddr_d, BASE, BYTES);
    widx   = AW'((awaddr_d - BASE) >> 2);
    mem_we = wcommit && whit;
    if (wcommit) begin
      bvalid_d = 1'b1;
      bresp_d  = whit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q  <= W_IDLE;
      wcnt_q    <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      wcnt_q    <= wcnt_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_d[b]) mem[widx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_23060240_axi_sram.sv
// Directed plus randomized bench over three responders: fixed latency
// (rd 0 / wr 2), fixed latency (rd 5 / wr 0) and LFSR-drawn latency.
module tb_ysyx_23060240_axi_sram;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, rready = 1'b0, bready = 1'b0;
  logic [1:0]  sel = 2'd0;

  ysyx_23060240_axi_sram_if bus [3] ();

  logic [2:0]  arr_a, rv_a, awr_a, wr_a, bv_a;
  logic [31:0] rd_a [3];
  logic [1:0]  rr_a [3], br_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_con
    assign bus[g].araddr  = araddr;
    assign bus[g].arvalid = arvalid && (sel == 2'(g));
    assign bus[g].rready  = rready;
    assign bus[g].awaddr  = awaddr;
    assign bus[g].awvalid = awvalid && (sel == 2'(g));
    assign bus[g].wdata   = wdata;
    assign bus[g].wstrb   = wstrb;
    assign bus[g].wvalid  = wvalid && (sel == 2'(g));
    assign bus[g].bready  = bready;
    assign arr_a[g] = bus[g].arready;
    assign rv_a[g]  = bus[g].rvalid;
    assign awr_a[g] = bus[g].awready;
    assign wr_a[g]  = bus[g].wready;
    assign bv_a[g]  = bus[g].bvalid;
    assign rd_a[g]  = bus[g].rdata;
    assign rr_a[g]  = bus[g].rresp;
    assign br_a[g]  = bus[g].bresp;
  end

  ysyx_23060240_axi_sram #(.BASE(BASE), .DEPTH(DEPTH), .RD_DELAY(0), .WR_DELAY(2), .RAND_DELAY(1'b0))
    u0 (.clk(clk), .rst(rst), .bus(bus[0]));
  ysyx_23060240_axi_sram #(.BASE(BASE), .DEPTH(DEPTH), .RD_DELAY(5), .WR_DELAY(0), .RAND_DELAY(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(bus[1]));
  ysyx_23060240_axi_sram #(.BASE(BASE), .DEPTH(DEPTH), .RD_DELAY(0), .WR_DELAY(0), .RAND_DELAY(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(bus[2]));

  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  always_comb begin
    case (sel)
      2'd0:    begin arready = arr_a[0]; rvalid = rv_a[0]; awready = awr_a[0]; wready = wr_a[0];
                     bvalid = bv_a[0]; rdata = rd_a[0]; rresp = rr_a[0]; bresp = br_a[0]; end
      2'd1:    begin arready = arr_a[1]; rvalid = rv_a[1]; awready = awr_a[1]; wready = wr_a[1];
                     bvalid = bv_a[1]; rdata = rd_a[1]; rresp = rr_a[1]; bresp = br_a[1]; end
      default: begin arready = arr_a[2]; rvalid = rv_a[2]; awready = awr_a[2]; wready = wr_a[2];
                     bvalid = bv_a[2]; rdata = rd_a[2]; rresp = rr_a[2]; bresp = br_a[2]; end
    endcase
  end

  // Reference: word arrays per responder and the latency each is built for (-1 = random 1..8)
  logic [31:0] mdl [3][DEPTH];
  int rlat_exp [3] = '{1, 6, -1};
  int wlat_exp [3] = '{3, 1, -1};
  bit [8:0] seen_lat = '0;
  int ncmp = 0, nerr = 0;

  function automatic bit hit(input logic [31:0] a);
    longint unsigned la;
    la = a;
    return (la >= BASE) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat, input int exp);
    if (exp < 0) begin
      chk(tag, 32'(lat >= 1 && lat <= 8), 32'd1);
      if (lat >= 1 && lat <= 8) seen_lat[lat] = 1'b1;
    end else chk(tag, 32'(lat), 32'(exp));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int alead, input int wlead, input int bhold);
    int n, lat, idx;
    bit awd, wd, ha, hw;
    logic [1:0] er;
    awaddr = a; wdata = d; wstrb = s; awd = 0; wd = 0; n = 0;
    while (!(awd && wd) && n < 40) begin
      if (!awd && n >= alead) awvalid = 1'b1;
      if (!wd && n >= wlead)  wvalid  = 1'b1;
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick(); n++;
      if (ha) begin awd = 1; awvalid = 1'b0; end
      if (hw) begin wd = 1;  wvalid  = 1'b0; end
      if (awd) chk("awready_low", 32'(awready), 32'd0);
      if (wd)  chk("wready_low", 32'(wready), 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(awd && wd)) chk("wr_handshake_timeout", 32'd0, 32'd1);
    lat = 1;
    while (!bvalid && lat < 40) begin tick(); lat++; end
    chk_lat("bvalid_latency", lat, wlat_exp[sel]);
    er = hit(a) ? 2'b00 : 2'b10;
    for (int i = 0; i < bhold; i++) begin
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(er));
      tick();
    end
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(er));
    bready = 1'b1; tick(); bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
    chk("wready_back", 32'(wready), 32'd1);
    if (hit(a)) begin
      idx = int'((a - BASE) >> 2);
      for (int b = 0; b < 4; b++) if (s[b]) mdl[sel][idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic rd(input logic [31:0] a, input int rhold);
    int n, lat;
    bit h;
    logic [31:0] ed;
    logic [1:0]  er;
    araddr = a; arvalid = 1'b1; n = 0; h = 0;
    while (!h && n < 40) begin h = arready; tick(); n++; end
    arvalid = 1'b0;
    if (!h) chk("rd_handshake_timeout", 32'd0, 32'd1);
    chk("arready_low", 32'(arready), 32'd0);
    lat = 1;
    while (!rvalid && lat < 40) begin tick(); lat++; end
    chk_lat("rvalid_latency", lat, rlat_exp[sel]);
    ed = hit(a) ? mdl[sel][int'((a - BASE) >> 2)] : 32'd0;
    er = hit(a) ? 2'b00 : 2'b10;
    for (int i = 0; i < rhold; i++) begin
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, ed);
      tick();
    end
    chk("rdata", rdata, ed);
    chk("rresp", 32'(rresp), 32'(er));
    rready = 1'b1; tick(); rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  task automatic reset_check();
    @(posedge clk); #2;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd1);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resps", 32'({rresp, bresp}), 32'd0);
    end
    tick(); tick();
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] a, d;
    int n;
    tick();
    reset_check();

    // Fill every word of every responder so later reads are fully defined
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      for (int i = 0; i < DEPTH; i++) wr(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
    end

    sel = 2'd0;
    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    rd(32'h8000_0010, 0);
    wr(32'h8000_0010, 32'h0000_AB00, 4'b0010, 0, 0, 0);
    rd(32'h8000_0010, 0);
    chk("partial_merge", mdl[0][4], 32'hDEAD_ABEF);
    wr(32'h8000_0020, $urandom, 4'hF, 3, 0, 4);
    rd(32'h8000_0020, 2);

    rd(32'h7FFF_FFFC, 0);
    wr(BASE + 32'(4 * DEPTH), 32'hDEAD_0000, 4'hF, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) rd(BASE + 32'(4 * i), 0);

    // Reset lands two cycles into a 5-cycle read wait
    sel = 2'd1;
    wr(32'h8000_0010, 32'hDEAD_ABEF, 4'hF, 0, 0, 0);
    araddr = 32'h8000_0010; arvalid = 1'b1; n = 0;
    while (!arready && n < 40) begin tick(); n++; end
    tick(); arvalid = 1'b0;
    tick(); #2;
    rst = 1'b0; #1;
    chk("abort_rvalid", 32'(rvalid), 32'd0);
    tick(); tick();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); chk("abort_no_rvalid", 32'(rvalid), 32'd0); end
    rd(32'h8000_0010, 0);
    chk("after_abort_rdata", rdata_last_ok(), 32'hDEAD_ABEF);

    // Randomized traffic on the fixed-latency and random-latency responders
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 2'd0 : 2'd2;
      for (int t = 0; t < 60; t++) begin
        if ($urandom_range(0, 7) == 0)
          a = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 4))
                                   : BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
        else
          a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
        d = $urandom;
        if ($urandom_range(0, 1) == 1)
          wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        else
          rd(a, $urandom_range(0, 2));
      end
    end
    chk("random_latency_varies", 32'($countones(seen_lat) > 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  function automatic logic [31:0] rdata_last_ok();
    return mdl[1][4];
  endfunction

endmodule

// File: doc/ysyx_23060240_axi_sram.md
Name: ysyx_23060240_axi_sram

Overview:
AXI4-Lite responder (slave) SRAM model; the far end of the IFU/LSU fetch and load/store master ports.
Serves word reads and byte-strobed writes from an internal array mapped at BASE, with programmable or pseudo-random response latency to stress master handshakes.
Read and write channels are independent FSMs sharing one memory array.

Parameters:
BASE, 32'h8000_0000, byte address of word 0
DEPTH, 4096, number of 32-bit words; must be a power of 2
RD_DELAY, 0, extra wait cycles before rvalid (fixed mode)
WR_DELAY, 0, extra wait cycles before bvalid (fixed mode)
RAND_DELAY, 0, 1 = per-transaction delay taken from the LFSR instead of RD_DELAY/WR_DELAY

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  32  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset (rst low, asynchronous): arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. FSMs go to IDLE, counters clear, LFSR loads 8'hA5. Memory contents are not reset. Reset mid-transaction aborts it silently.
- Addressing: index = (addr-BASE)>>2; addr[1:0] ignored. In range iff BASE <= addr < BASE+4*DEPTH. Otherwise resp=SLVERR (2'b10), rdata=0, and no write occurs. In-range resp=OKAY (2'b00).
- Read FSM states: R_IDLE (arready=1), R_WAIT (count down), R_RESP (rvalid=1).
  - The handshake on arvalid&&arready latches araddr, and arready drops the next cycle.
  - rvalid first rises exactly D+1 cycles after the handshake cycle (D = RD_DELAY or the LFSR value).
  - rdata is sampled from memory on the edge that enters R_RESP.
  - rdata, rresp and rvalid are held stable until rready. On rvalid&&rready the FSM returns to R_IDLE, so arready=1 the next cycle.
  - Back-to-back throughput with D=0 is one read per 2 cycles.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - AW and W are accepted independently, in either order or in the same cycle. Each ready drops after its own handshake and stays low until the B handshake completes.
  - Once both are captured, the FSM counts D (WR_DELAY or the LFSR value).
  - On the edge entering W_RESP, memory is written for bytes whose wstrb bit is 1. bvalid rises exactly D+1 cycles after the later of the AW/W handshakes.
  - bvalid and bresp are held until bready, then the FSM returns to W_IDLE.
- Read/write collision: if a read sample and a write commit hit the same word on the same edge, the read returns the OLD data.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle. Delay = lfsr[2:0] (0..7), sampled at address acceptance.
- No combinational path exists from any input to any output; all outputs are registered.
- No outstanding-transaction queue: depth is one per channel.

Decomposition:
- Package ysyx_23060240_axi_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - read-state and write-state enums
  - LFSR seed and tap constant
- One sub-module: ysyx_23060240_lfsr8 (clk, rst, out[7:0]).

Test Plan:
1. Reset: assert rst low mid-cycle -> within the same cycle rvalid=bvalid=0, arready=awready=wready=1, rdata=0.
2. WR_DELAY=2, write 0x8000_0010 data 0xDEADBEEF strb 4'hF (AW and W same cycle) -> bvalid high 3 cycles later, bresp=00. Then read 0x8000_0010 with RD_DELAY=0 -> rvalid 1 cycle after the AR handshake, rdata=0xDEADBEEF, rresp=00.
3. Partial write to 0x8000_0010, data 0x0000AB00 strb 4'b0010 -> subsequent read returns 0xDEADABEF.
4. W presented 3 cycles before AW, bready held low 4 cycles -> wready low after the W handshake. bvalid and bresp stay stable for 4 cycles. awready/wready return to 1 the cycle after the B handshake.
5. Read 0x7FFF_FFFC -> rresp=10, rdata=0. Write 0xDEAD0000 to BASE+4*DEPTH -> bresp=10, and a readback of every word is unchanged.
6. RD_DELAY=5, rst pulled low 2 cycles after the AR handshake -> rvalid never rises. After release, a read of 0x8000_0010 returns 0xDEADABEF with rvalid 6 cycles after its handshake.
